axis_pkt_arbiter: RTL and testbench

AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

---
 rtl/axis_pkt_arbiter.sv | 134 +++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arbiter.sv
// Two-source AXI-Stream packet arbiter with round-robin contention handling.
// Optional per-source completed-packet counters are enabled by ARB_PKT_STATS_EN.
module axis_pkt_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tvalid,
  input  logic              s0_axis_tlast,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tvalid,
  input  logic              s1_axis_tlast,
  output logic              s1_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [1:0]        grant,
  output logic [15:0]       pkt_cnt0,
  output logic [15:0]       pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 0: source 0 served last, 1: source 1
  logic [1:0]  grant_q, grant_d;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    m_axis_tdata   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          if (last_grant_q) begin
            state_d      = GNT0;
            last_grant_d = 1'b0;
          end else begin
            state_d      = GNT1;
            last_grant_d = 1'b1;
          end
        end else if (s0_axis_tvalid) begin
          state_d      = GNT0;
          last_grant_d = 1'b0;
        end else if (s1_axis_tvalid) begin
          state_d      = GNT1;
          last_grant_d = 1'b1;
        end
      end
      GNT0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        s0_axis_tready = m_axis_tready;
        if (s0_axis_tvalid && m_axis_tready && s0_axis_tlast) state_d = IDLE;
      end
      GNT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
        if (s1_axis_tvalid && m_axis_tready && s1_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is decoded from the next state so the registered value tracks state_q.
  always_comb begin
    case (state_d)
      GNT0:    grant_d = 2'b01;
      GNT1:    grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  assign grant = grant_q;

`ifdef ARB_PKT_STATS_EN
  logic [15:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [15:0] pkt_cnt1_q, pkt_cnt1_d;
  logic        done0, done1;

  assign done0 = (state_q == GNT0) && s0_axis_tvalid && m_axis_tready && s0_axis_tlast;
  assign done1 = (state_q == GNT1) && s1_axis_tvalid && m_axis_tready && s1_axis_tlast;

  always_comb begin
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    if (done0) pkt_cnt0_d = pkt_cnt0_q + 16'd1;
    if (done1) pkt_cnt1_d = pkt_cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pkt_cnt0_q <= 16'd0;
      pkt_cnt1_q <= 16'd0;
    end else begin
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
`else
  assign pkt_cnt0 = 16'd0;
  assign pkt_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench for axis_pkt_arbiter: directed packets, expected beats queued
// up front and checked by an independent monitor on every accepted output beat.
module tb_axis_pkt_arbiter;
  localparam int DATA_W = 8;
`ifdef ARB_PKT_STATS_EN
  localparam bit STATS = 1'b1;
  localparam int N_BULK = 65536;
`else
  localparam bit STATS = 1'b0;
  localparam int N_BULK = 8;
`endif

  logic clk = 1'b0;
  logic nrst;
  logic [DATA_W-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [1:0] grant;
  logic [15:0] pkt_cnt0, pkt_cnt1;

  always #5 clk = ~clk;

  axis_pkt_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .nrst(nrst),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_cnt0 = 16'd0;
  logic [15:0] exp_cnt1 = 16'd0;
  logic [10:0] exp_q[$];   // {grant one-hot, data, last}
  logic [10:0] mon_act, mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int src, input logic [7:0] d, input logic l);
    exp_q.push_back({(src == 1) ? 2'b10 : 2'b01, d, l});
  endtask

  // Monitor: every accepted beat (outside reset) must match the queue head.
  always @(negedge clk) begin
    if (nrst && m_axis_tvalid && m_axis_tready) begin
      mon_act = {grant, m_axis_tdata, m_axis_tlast};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got 0x%0h expected none at %0t", mon_act, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("beat", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int src, input logic v, input logic [7:0] d, input logic l);
    if (src == 0) begin
      s0_axis_tvalid = v; s0_axis_tdata = d; s0_axis_tlast = l;
    end else begin
      s1_axis_tvalid = v; s1_axis_tdata = d; s1_axis_tlast = l;
    end
  endtask

  task automatic wait_accept(input int src);
    int  n;
    logic acc;
    n = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = (src == 0) ? s0_axis_tready : s1_axis_tready;
      n++;
      if (!acc && n > 300) begin
        n_bad++;
        $display("FAIL timeout_src%0d: got no tready expected tready within 300 cycles", src);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "bench stopped on timeout");
      end
    end
    step();
  endtask

  task automatic send(input int src, input logic [31:0] bytes, input int len,
                      input int gap_after, input int gap_len);
    for (int i = 0; i < len; i++) begin
      drive(src, 1'b1, bytes[8*i +: 8], (i == len - 1));
      wait_accept(src);
      if (i == gap_after) begin
        drive(src, 1'b0, 8'h00, 1'b0);
        for (int g = 0; g < gap_len; g++) begin
          #1;
          chk("gap_grant", 32'(grant), (src == 0) ? 32'h1 : 32'h2);
          chk("gap_mvalid", 32'(m_axis_tvalid), 32'h0);
          chk("gap_other_rdy", (src == 0) ? 32'(s1_axis_tready) : 32'(s0_axis_tready), 32'h0);
          step();
        end
      end
    end
    drive(src, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic pkt_done(input int src);
    if (STATS) begin
      if (src == 0) exp_cnt0 = exp_cnt0 + 16'd1;
      else          exp_cnt1 = exp_cnt1 + 16'd1;
    end
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_cnt0"}, 32'(pkt_cnt0), 32'(exp_cnt0));
    chk({tag, "_cnt1"}, 32'(pkt_cnt1), 32'(exp_cnt1));
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    exp_cnt0 = 16'd0;
    exp_cnt1 = 16'd0;
  endtask

  initial begin
    nrst = 1'b0;
    m_axis_tready = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_s0_rdy", 32'(s0_axis_tready), 32'h0);
    chk("rst_s1_rdy", 32'(s1_axis_tready), 32'h0);
    chk_cnts("rst");
    nrst = 1'b1;
    m_axis_tready = 1'b1;
    step();
    chk("idle_mvalid", 32'(m_axis_tvalid), 32'h0);
    chk("idle_grant", 32'(grant), 32'h0);

    // Single source, three beats
    push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
    drive(0, 1'b1, 8'hA1, 1'b0);
    #1;
    chk("t1_grant_pre", 32'(grant), 32'h0);
    chk("t1_mvalid_pre", 32'(m_axis_tvalid), 32'h0);
    step();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_s0_rdy", 32'(s0_axis_tready), 32'h1);
    send(0, 32'h00A3A2A1, 3, -1, 0);
    #1;
    chk("t1_idle", 32'(grant), 32'h0);
    pkt_done(0);
    chk_cnts("t1");

    // Contention straight after reset: source 0 first, bubble, then source 1
    do_reset();
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1); push(1, 8'h20, 1'b1);
    fork
      begin
        send(0, 32'h00001110, 2, -1, 0);
        #1;
        chk("t2_bubble_grant", 32'(grant), 32'h0);
        chk("t2_bubble_s1_rdy", 32'(s1_axis_tready), 32'h0);
      end
      send(1, 32'h00000020, 1, -1, 0);
    join
    pkt_done(0); pkt_done(1);
    push(0, 8'h12, 1'b1); push(1, 8'h21, 1'b1);
    fork
      send(0, 32'h00000012, 1, -1, 0);
      send(1, 32'h00000021, 1, -1, 0);
    join
    pkt_done(0); pkt_done(1);
    chk_cnts("t2");

    // Source 0 served last, so contention now goes to source 1
    push(0, 8'h60, 1'b1);
    send(0, 32'h00000060, 1, -1, 0);
    push(1, 8'h70, 1'b1); push(0, 8'h61, 1'b1);
    fork
      send(0, 32'h00000061, 1, -1, 0);
      send(1, 32'h00000070, 1, -1, 0);
    join
    pkt_done(0); pkt_done(0); pkt_done(1);
    chk_cnts("t3");

    // Backpressure on the tlast beat of source 1
    push(1, 8'h30, 1'b0); push(1, 8'h31, 1'b1);
    drive(1, 1'b1, 8'h30, 1'b0);
    step();
    chk("t4_grant", 32'(grant), 32'h2);
    step();
    drive(1, 1'b1, 8'h31, 1'b1);
    m_axis_tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_stall_rdy", 32'(s1_axis_tready), 32'h0);
      chk("t4_stall_grant", 32'(grant), 32'h2);
      step();
    end
    m_axis_tready = 1'b1;
    #1;
    chk("t4_release_rdy", 32'(s1_axis_tready), 32'h1);
    step();
    chk("t4_idle", 32'(grant), 32'h0);
    drive(1, 1'b0, 8'h00, 1'b0);
    pkt_done(1);
    chk_cnts("t4");

    // Source 0 valid gap mid-packet while source 1 waits
    push(0, 8'h80, 1'b0); push(0, 8'h81, 1'b1); push(1, 8'h90, 1'b1);
    fork
      send(0, 32'h00008180, 2, 0, 2);
      send(1, 32'h00000090, 1, -1, 0);
    join
    pkt_done(0); pkt_done(1);
    chk_cnts("t5");

    // Reset during beat 2 of a source 1 packet
    push(1, 8'h40, 1'b0);
    drive(1, 1'b1, 8'h40, 1'b0);
    step();
    chk("t6_grant", 32'(grant), 32'h2);
    step();
    drive(1, 1'b1, 8'h41, 1'b1);
    nrst = 1'b0;
    step();
    exp_cnt0 = 16'd0;
    exp_cnt1 = 16'd0;
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_s0_rdy", 32'(s0_axis_tready), 32'h0);
    chk("t6_rst_s1_rdy", 32'(s1_axis_tready), 32'h0);
    chk_cnts("t6_rst");
    push(0, 8'h50, 1'b1); push(1, 8'h41, 1'b1);
    nrst = 1'b1;
    fork
      send(0, 32'h00000050, 1, -1, 0);
      begin
        wait_accept(1);
        drive(1, 1'b0, 8'h00, 1'b0);
      end
    join
    pkt_done(0); pkt_done(1);
    chk_cnts("t6");

    // Back-to-back one-beat packets; with stats on this wraps pkt_cnt0
    do_reset();
    for (int i = 0; i < N_BULK; i++) begin
      push(0, 8'(i), 1'b1);
      send(0, 32'(8'(i)), 1, -1, 0);
      pkt_done(0);
      if (i == N_BULK - 2) chk_cnts("bulk_pre");
    end
    chk_cnts("bulk_end");

    repeat (3) step();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
